// File: rtl/sobel_stream_filter.sv
// Streaming 3x3 Sobel edge filter over a raster-order grayscale frame.
// Two line buffers and a 3x3 window feed a registered magnitude/threshold stage.
module sobel_stream_filter #(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480,
  parameter int unsigned DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    mode_i,
  input  logic [DW-1:0] thresh_i,
  input  logic          valid_i,
  input  logic [DW-1:0] grayscale_i,
  output logic          ready_o,
  output logic          valid_o,
  output logic [DW-1:0] grayscale_o,
  output logic          done_o,
  output logic          busy_o
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam int unsigned FW = $clog2(IMG_W + 2);
  localparam int unsigned GW = DW + 3;

  typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

  state_e        state_q;
  logic [CW-1:0] col_q, ocol_q;
  logic [RW-1:0] row_q, orow_q;
  logic [FW-1:0] fl_cnt_q;
  logic [1:0]    mode_q;
  logic [DW-1:0] thresh_q;
  logic          s1_valid_q, s1_last_q, s1_border_q;

  logic [DW-1:0] lb0 [IMG_W];
  logic [DW-1:0] lb1 [IMG_W];
  logic [DW-1:0] win_q [9];

  logic          accept, in_flush, adv_flush, adv, primed, emit, col_last, row_last;
  logic [DW-1:0] px;

  assign ready_o = (state_q != StFlush);

  always_comb begin
    accept    = valid_i & ready_o;
    in_flush  = (state_q == StFlush);
    // Flush injects IMG_W+1 dummy pixels to push the last rows through the window.
    adv_flush = in_flush && (fl_cnt_q <= FW'(IMG_W));
    adv       = accept | adv_flush;
    col_last  = (col_q == CW'(IMG_W - 1));
    row_last  = (row_q == RW'(IMG_H - 1));
    // An output exists once the input index reaches IMG_W+1.
    primed    = (row_q != '0) && !((row_q == RW'(1)) && (col_q == '0));
    emit      = adv_flush | (accept & primed);
    px        = in_flush ? '0 : grayscale_i;
  end

  function automatic logic signed [GW-1:0] ext(input logic [DW-1:0] v);
    return signed'({3'b000, v});
  endfunction

  function automatic logic [DW-1:0] sat(input logic [GW:0] v);
    return (|v[GW:DW]) ? '1 : v[DW-1:0];
  endfunction

  logic signed [GW-1:0] gx, gy;
  logic [GW-1:0]        ax, ay;
  logic [GW:0]          mag;
  logic [DW-1:0]        result;

  always_comb begin
    gx = (ext(win_q[2]) + (ext(win_q[5]) <<< 1) + ext(win_q[8]))
       - (ext(win_q[0]) + (ext(win_q[3]) <<< 1) + ext(win_q[6]));
    gy = (ext(win_q[6]) + (ext(win_q[7]) <<< 1) + ext(win_q[8]))
       - (ext(win_q[0]) + (ext(win_q[1]) <<< 1) + ext(win_q[2]));
    ax  = gx[GW-1] ? $unsigned(-gx) : $unsigned(gx);
    ay  = gy[GW-1] ? $unsigned(-gy) : $unsigned(gy);
    mag = {1'b0, ax} + {1'b0, ay};
    result = '0;
    case (mode_q)
      2'b00:   result = sat(mag);
      2'b01:   result = sat({1'b0, ax});
      2'b10:   result = sat({1'b0, ay});
      default: result = (mag >= {{(GW + 1 - DW){1'b0}}, thresh_q}) ? '1 : '0;
    endcase
  end

  // Line buffers and window carry no reset; borders mask any stale rows.
  always_ff @(posedge clk) begin
    if (adv) begin
      lb0[col_q] <= lb1[col_q];
      lb1[col_q] <= px;
      win_q[0]   <= win_q[1];
      win_q[1]   <= win_q[2];
      win_q[2]   <= lb0[col_q];
      win_q[3]   <= win_q[4];
      win_q[4]   <= win_q[5];
      win_q[5]   <= lb1[col_q];
      win_q[6]   <= win_q[7];
      win_q[7]   <= win_q[8];
      win_q[8]   <= px;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      col_q       <= '0;
      row_q       <= '0;
      ocol_q      <= '0;
      orow_q      <= '0;
      fl_cnt_q    <= '0;
      mode_q      <= '0;
      thresh_q    <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_border_q <= 1'b0;
      valid_o     <= 1'b0;
      grayscale_o <= '0;
      done_o      <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      valid_o     <= s1_valid_q;
      grayscale_o <= (s1_valid_q && !s1_border_q) ? result : '0;
      done_o      <= s1_valid_q & s1_last_q;

      s1_valid_q <= emit;
      if (emit) begin
        s1_last_q   <= (orow_q == RW'(IMG_H - 1)) && (ocol_q == CW'(IMG_W - 1));
        s1_border_q <= (orow_q == '0) || (orow_q == RW'(IMG_H - 1)) ||
                       (ocol_q == '0) || (ocol_q == CW'(IMG_W - 1));
        if (ocol_q == CW'(IMG_W - 1)) begin
          ocol_q <= '0;
          orow_q <= (orow_q == RW'(IMG_H - 1)) ? '0 : orow_q + 1'b1;
        end else begin
          ocol_q <= ocol_q + 1'b1;
        end
      end

      if (adv) begin
        if (col_last) begin
          col_q <= '0;
          if (accept) row_q <= row_last ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end

      case (state_q)
        StIdle: begin
          if (accept) begin
            state_q  <= StRun;
            busy_o   <= 1'b1;
            mode_q   <= mode_i;
            thresh_q <= thresh_i;
          end
        end
        StRun: begin
          if (accept && col_last && row_last) begin
            state_q  <= StFlush;
            fl_cnt_q <= '0;
          end
        end
        StFlush: begin
          if (adv_flush) fl_cnt_q <= fl_cnt_q + 1'b1;
          if (done_o) begin
            state_q <= StIdle;
            busy_o  <= 1'b0;
            col_q   <= '0;
            row_q   <= '0;
            ocol_q  <= '0;
            orow_q  <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_stream_filter.sv
// Directed bench for sobel_stream_filter on a 4x3 frame: values, latency, flush,
// reset abort and mode capture.
module tb_sobel_stream_filter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] mode_i = 2'b00;
  logic [7:0] thresh_i = 8'd0;
  logic       valid_i = 1'b0;
  logic [7:0] grayscale_i = 8'd0;
  logic       ready_o, valid_o, done_o, busy_o;
  logic [7:0] grayscale_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] img  [12];
  logic [7:0] expv [12];

  sobel_stream_filter #(.IMG_W(4), .IMG_H(3), .DW(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .mode_i      (mode_i),
    .thresh_i    (thresh_i),
    .valid_i     (valid_i),
    .grayscale_i (grayscale_i),
    .ready_o     (ready_o),
    .valid_o     (valid_o),
    .grayscale_o (grayscale_o),
    .done_o      (done_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic set_uniform(input logic [7:0] v);
    for (int i = 0; i < 12; i++) img[i] = v;
  endtask

  // Columns 0-1 dark, columns 2-3 bright.
  task automatic set_vert();
    for (int i = 0; i < 12; i++) img[i] = ((i % 4) >= 2) ? 8'd255 : 8'd0;
  endtask

  // Row 0 dark, rows 1-2 at 50.
  task automatic set_horiz();
    for (int i = 0; i < 12; i++) img[i] = (i < 4) ? 8'd0 : 8'd50;
  endtask

  // Only interior pixels (1,1) and (1,2) can be non-zero in a 4x3 frame.
  task automatic set_exp(input logic [7:0] v);
    for (int i = 0; i < 12; i++) expv[i] = 8'd0;
    expv[5] = v;
    expv[6] = v;
  endtask

  task automatic run_frame(input logic [1:0] mode, input logic [7:0] thr, input bit gaps,
                           input int abort_after, input bit mid_change);
    int nacc = 0;
    int nout = 0;
    int cyc = 0;
    int last_acc = 0;
    int acc_cyc [12];
    int trig, exp_cyc;
    bit seen_done = 0;
    bit want;
    mode_i   = mode;
    thresh_i = thr;
    while (!seen_done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (valid_o) begin
        if (nout < 12) begin
          trig    = nout + 5;
          exp_cyc = (trig < 12) ? acc_cyc[trig] + 2 : last_acc + 2 + (trig - 11);
          chk($sformatf("pix%0d", nout), int'(grayscale_o), int'(expv[nout]));
          chk($sformatf("lat%0d", nout), cyc, exp_cyc);
          chk($sformatf("done%0d", nout), int'(done_o), int'(nout == 11));
        end else begin
          chk("extra_out", int'(valid_o), 0);
        end
        if (done_o) seen_done = 1;
        nout++;
      end else begin
        chk("idle_zero", int'(grayscale_o), 0);
        chk("idle_done", int'(done_o), 0);
      end
      if (nacc > 0) chk("busy", int'(busy_o), 1);
      if (nacc == 12) chk("flush_ready", int'(ready_o), 0);
      if (abort_after > 0 && nacc >= abort_after) break;
      want        = (nacc < 12) && (!gaps || ((cyc * 5) % 7 < 4));
      valid_i     = want || (gaps && nacc == 12 && !seen_done);
      grayscale_i = want ? img[nacc] : 8'd77;
      if (valid_i && ready_o && nacc < 12) begin
        acc_cyc[nacc] = cyc;
        last_acc      = cyc;
        nacc++;
      end
      if (mid_change && nacc == 6) mode_i = 2'b10;
    end
    if (abort_after == 0) begin
      chk("frame_done", int'(seen_done), 1);
      chk("out_count", nout, 12);
    end
  endtask

  task automatic post_frame();
    valid_i = 1'b0;
    @(negedge clk);
    chk("busy_fall", int'(busy_o), 0);
    chk("post_valid", int'(valid_o), 0);
    chk("post_ready", int'(ready_o), 1);
  endtask

  task automatic chk_reset_state();
    chk("rst_ready", int'(ready_o), 1);
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_pix", int'(grayscale_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_busy", int'(busy_o), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_state();
    rst = 1'b1;

    // Uniform frame: all zero, first output two cycles after 6th pixel.
    set_uniform(8'd100); set_exp(8'd0);
    run_frame(2'b00, 8'd0, 1'b0, 0, 1'b0); post_frame();

    // Vertical edge in modes 00, 01, 10.
    set_vert(); set_exp(8'd255);
    run_frame(2'b00, 8'd0, 1'b0, 0, 1'b0); post_frame();
    run_frame(2'b01, 8'd0, 1'b0, 0, 1'b0); post_frame();
    set_exp(8'd0);
    run_frame(2'b10, 8'd0, 1'b0, 0, 1'b0); post_frame();

    // Threshold mode on a horizontal edge of magnitude 200.
    set_horiz(); set_exp(8'd255);
    run_frame(2'b11, 8'd200, 1'b0, 0, 1'b0); post_frame();
    set_exp(8'd0);
    run_frame(2'b11, 8'd201, 1'b0, 0, 1'b0); post_frame();

    // Vertical edge with input gaps and junk offered during flush.
    set_vert(); set_exp(8'd255);
    run_frame(2'b00, 8'd0, 1'b1, 0, 1'b0); post_frame();

    // Reset after 7 accepted pixels abandons the frame.
    set_uniform(8'd100); set_exp(8'd0);
    run_frame(2'b00, 8'd0, 1'b0, 7, 1'b0);
    valid_i = 1'b0;
    rst     = 1'b0;
    @(negedge clk);
    chk_reset_state();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_quiet", int'(valid_o), 0);
      chk("abort_nodone", int'(done_o), 0);
    end
    run_frame(2'b00, 8'd0, 1'b0, 0, 1'b0); post_frame();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_extra", int'(valid_o), 0);
    end

    // Mode changed mid-frame takes effect only on the next frame.
    set_vert(); set_exp(8'd255);
    run_frame(2'b00, 8'd0, 1'b0, 0, 1'b1); post_frame();
    set_exp(8'd0);
    run_frame(2'b10, 8'd0, 1'b0, 0, 1'b0); post_frame();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sobel_stream_filter.md
SOBEL_STREAM_FILTER -- requirements
Module: sobel_stream_filter

Interface
REQ-001 Parameter IMG_W, default 640, pixels per line, at least 3.
REQ-002 Parameter IMG_H, default 480, lines per frame, at least 3.
REQ-003 Parameter DW, default 8, pixel bit width.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-low reset; sampled only on a clk rising edge.
REQ-006 mode_i  input  2  output mode select, sampled at frame start.
REQ-007 thresh_i  input  DW  binarisation threshold, sampled at frame start.
REQ-008 valid_i  input  1  grayscale_i carries a pixel.
REQ-009 grayscale_i  input  DW  input pixel, raster order, row 0 column 0 first.
REQ-010 ready_o  output  1  block accepts a pixel this cycle; a pixel transfers on valid_i and ready_o both high.
REQ-011 valid_o  output  1  grayscale_o carries an output pixel.
REQ-012 grayscale_o  output  DW  filtered pixel, raster order.
REQ-013 done_o  output  1  one-cycle pulse, coincident with the last output pixel of a frame.
REQ-014 busy_o  output  1  high from the first accepted pixel until done_o has pulsed.

Function
REQ-015 States: IDLE, RUN, FLUSH. IDLE goes to RUN on the first accepted pixel. RUN goes to FLUSH when pixel (IMG_H-1, IMG_W-1) is accepted. FLUSH goes to IDLE in the cycle done_o pulses.
REQ-016 ready_o is high in IDLE and RUN and low in FLUSH; pixels offered during FLUSH are not consumed.
REQ-017 mode_i and thresh_i are captured on the first accepted pixel and held for the whole frame; changes mid-frame have no effect.
REQ-018 Two line buffers, each IMG_W x DW, plus a 3x3 window form d0..d8, row-major, with d0 at the top-left and pixel (r,c) at d4.
REQ-019 Gx = (d2 + 2*d5 + d8) - (d0 + 2*d3 + d6); Gy = (d6 + 2*d7 + d8) - (d0 + 2*d1 + d2); both signed, DW+3 bits, with no overflow.
REQ-020 Output value for each mode_i setting:
- 00: |Gx| + |Gy|, saturated to 2^DW-1.
- 01: |Gx|, saturated.
- 10: |Gy|, saturated.
- 11: 2^DW-1 if |Gx| + |Gy| >= thresh_i, else 0.
REQ-021 Border pixels (row 0, row IMG_H-1, column 0, column IMG_W-1) output 0 in all modes.
REQ-022 Exactly IMG_W*IMG_H outputs are produced per frame, one per valid_o cycle, in raster order.
REQ-023 Output (r,c) is emitted exactly 2 cycles after input (r+1,c+1) is accepted. Where that input does not exist, the output is emitted during FLUSH.
REQ-024 FLUSH emits the remaining outputs, one per consecutive cycle, starting 2 cycles after entry.
REQ-025 Input stalls (valid_i low) stall output generation with no loss or duplication; the latency in REQ-023 is counted from acceptance, not from cycle count.
REQ-026 Pixel and line counters wrap to 0 at IMG_W-1 and IMG_H-1 respectively.
REQ-027 Back-to-back frames: the next frame's first pixel is accepted no earlier than the cycle after done_o.
REQ-028 When valid_o is low, grayscale_o is 0.

Reset
REQ-029 While rst is low at a clock edge, the block applies reset:
- state returns to IDLE and all counters clear;
- ready_o=1, valid_o=0, grayscale_o=0, done_o=0, busy_o=0;
- captured mode_i and thresh_i clear to 0.
REQ-030 Reset applied mid-frame abandons the frame: no further valid_o and no done_o. The next accepted pixel is treated as pixel (0,0).
REQ-031 Line buffer contents need not be cleared by reset, and stale data never reaches grayscale_o.

Verification
REQ-032 Setup for all scenarios: IMG_W=4, IMG_H=3, DW=8.
REQ-033 Uniform frame, all pixels 100, mode 00, gapless input.
- Expect 12 outputs, all 0.
- First valid_o exactly 2 cycles after the 6th pixel is accepted.
- done_o pulses with the 12th output; busy_o falls after it.
REQ-034 Vertical edge, columns 0-1 = 0 and columns 2-3 = 255.
- Mode 00: outputs (1,1) and (1,2) = 255; all others 0.
- Mode 01: same result.
- Mode 10: all outputs 0.
REQ-035 Threshold mode 11, thresh_i=200, horizontal edge (row 0 = 0, rows 1-2 = 50).
- Interior magnitude is 200, so (1,1) and (1,2) = 255.
- Repeat with thresh_i=201: (1,1) and (1,2) = 0.
REQ-036 Random valid_i gaps on the vertical-edge frame.
- Output sequence identical to REQ-034.
- Each output 2 cycles after its triggering pixel.
- ready_o low throughout FLUSH.
REQ-037 rst driven low after 7 accepted pixels, then a full uniform frame of 100.
- Outputs immediately 0 and the frame is abandoned.
- Second frame yields 12 outputs of 0 and one done_o; no extra outputs.
REQ-038 mode_i changed from 00 to 10 mid-frame on the vertical-edge frame.
- Output matches mode 00 results.
- The next frame uses mode 10.
